// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART byte path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  function automatic int tick_width(input int oversample);
    return $clog2(oversample);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int oversample, input int data_bits,
                                   input int parity_en, input int parity_odd,
                                   input int stop_bits);
    return is_pow2(oversample) && (oversample >= 2) && (oversample <= 256) &&
           (data_bits >= 5) && (data_bits <= 8) &&
           (parity_en == 0 || parity_en == 1) &&
           (parity_odd == 0 || parity_odd == 1) &&
           (stop_bits == 1 || stop_bits == 2);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1 while running and flags
// the last tick of each bit period. Shared by the tx path and a future rx path.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clkout,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  localparam int TW = tick_width(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt;

  // Power-of-two period lets the counter roll over to zero on its own.
  always_ff @(posedge clkout) begin
    if (reset || clear) begin
      tick_cnt <= '0;
    end else if (run) begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign wrap = run && (tick_cnt == TICK_LAST);

endmodule

// File: rtl/uart_tx_byte.sv
// UART byte transmitter: latches a byte on a rising wrsig edge and sends
// start, data LSB-first, optional parity and stop bit(s). idle=1 means busy.
//
// state    | meaning
// S_IDLE   | line high, waiting for a wrsig rising edge
// S_START  | start bit (tx=0)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only when PARITY_EN=1)
// S_STOP   | stop bit(s) (tx=1)
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clkout,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       idle,
  output logic       tx
);

  if (!params_ok(OVERSAMPLE, DATA_BITS, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_param_err
    $error("uart_tx_byte: parameter out of range");
  end

  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       PAR_SENSE = (PARITY_ODD != 0);

  uart_state_t          state, state_nxt;
  logic                 wrsig_d;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 parity_bit, parity_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 tx_nxt, idle_nxt;
  logic                 req, accept, wrap;

  // Upper datain bits are deliberately dropped when DATA_BITS < 8.
  logic unused_datain;
  assign unused_datain = ^datain;

  assign req = wrsig & ~wrsig_d;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clkout (clkout),
    .reset  (reset),
    .clear  (accept),
    .run    (state != S_IDLE),
    .wrap   (wrap)
  );

  // State and registered line outputs; wrsig_d resets high so a strobe held
  // through reset is not mistaken for a new request.
  always_ff @(posedge clkout) begin
    if (reset) begin
      state      <= S_IDLE;
      wrsig_d    <= 1'b1;
      shreg      <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      idle       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wrsig_d    <= wrsig;
      shreg      <= shreg_nxt;
      parity_bit <= parity_nxt;
      bit_cnt    <= bit_cnt_nxt;
      tx         <= tx_nxt;
      idle       <= idle_nxt;
    end
  end

  // Next state and the tx level of the bit about to start; tx is registered
  // so it switches on the same edge as the state.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    parity_nxt  = parity_bit;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx;
    idle_nxt    = idle;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        idle_nxt = 1'b0;
        if (req) begin
          accept     = 1'b1;
          shreg_nxt  = datain[DATA_BITS-1:0];
          parity_nxt = (^datain[DATA_BITS-1:0]) ^ PAR_SENSE;
          tx_nxt     = 1'b0;
          idle_nxt   = 1'b1;
          state_nxt  = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            if (PARITY_EN != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            shreg_nxt   = shreg >> 1;
            bit_cnt_nxt = bit_cnt + 3'd1;
            tx_nxt      = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_nxt   = S_STOP;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b1;
        end
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (wrap) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            idle_nxt    = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
        idle_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte: three configurations share one stimulus stream and
// are compared every cycle against a frame-level reference model.
module tb_uart_tx_byte;

  localparam int N = 3;

  logic         clk;
  logic         reset;
  logic         wrsig;
  logic [7:0]   datain;
  logic [N-1:0] idle_v;
  logic [N-1:0] tx_v;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_busy [N];
  int          m_cnt  [N];
  logic [15:0] m_frame[N];
  bit          m_prev;

  // frame decoder state
  int          d_cyc   [N];
  bit          d_prev  [N];
  logic [15:0] cap     [N];
  int          last_len[N];
  int          frames  [N];

  uart_tx_byte #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clkout(clk), .reset(reset), .datain(datain), .wrsig(wrsig), .idle(idle_v[0]), .tx(tx_v[0]));
  uart_tx_byte #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clkout(clk), .reset(reset), .datain(datain), .wrsig(wrsig), .idle(idle_v[1]), .tx(tx_v[1]));
  uart_tx_byte #(.OVERSAMPLE(4), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clkout(clk), .reset(reset), .datain(datain), .wrsig(wrsig), .idle(idle_v[2]), .tx(tx_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int f_os(int i);  return (i == 2) ? 4 : 16; endfunction
  function automatic int f_db(int i);  return (i == 2) ? 7 : 8;  endfunction
  function automatic int f_pe(int i);  return (i == 0) ? 0 : 1;  endfunction
  function automatic int f_po(int i);  return (i == 2) ? 1 : 0;  endfunction
  function automatic int f_sb(int i);  return (i == 2) ? 2 : 1;  endfunction
  function automatic int f_len(int i);
    return f_os(i) * (1 + f_db(i) + f_pe(i) + f_sb(i));
  endfunction

  // Line levels of one frame, bit 0 = start bit; unused high bits stay 1.
  function automatic logic [15:0] f_frame(int i, logic [7:0] d);
    logic [15:0] fr;
    int ones;
    fr    = '1;
    fr[0] = 1'b0;
    ones  = 0;
    for (int k = 0; k < f_db(i); k++) begin
      fr[1+k] = d[k];
      ones += int'(d[k]);
    end
    if (f_pe(i) != 0) begin
      fr[1+f_db(i)] = ((ones % 2) != f_po(i));
    end
    return fr;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model update, per-cycle comparison and frame capture, 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 1'b0;
        m_cnt[i]  = 0;
      end
      m_prev = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == f_len(i)) m_busy[i] = 1'b0;
        end else if (wrsig && !m_prev) begin
          m_busy[i]  = 1'b1;
          m_cnt[i]   = 0;
          m_frame[i] = f_frame(i, datain);
        end
      end
      m_prev = wrsig;
    end
    for (int i = 0; i < N; i++) begin
      logic exp_tx;
      exp_tx = m_busy[i] ? m_frame[i][m_cnt[i] / f_os(i)] : 1'b1;
      check_val($sformatf("tx%0d", i), 32'(tx_v[i]), 32'(exp_tx));
      check_val($sformatf("idle%0d", i), 32'(idle_v[i]), 32'(m_busy[i]));
      if (idle_v[i]) begin
        if (!d_prev[i]) begin
          d_cyc[i] = 0;
          cap[i]   = '1;
          frames[i]++;
        end
        if ((d_cyc[i] % f_os(i)) == f_os(i) / 2 && (d_cyc[i] / f_os(i)) < 16)
          cap[i][d_cyc[i] / f_os(i)] = tx_v[i];
        d_cyc[i]++;
      end else if (d_prev[i]) begin
        last_len[i] = d_cyc[i];
      end
      d_prev[i] = idle_v[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d, input int w);
    datain = d;
    wrsig  = 1'b1;
    tick(w);
    wrsig  = 1'b0;
  endtask

  task automatic wait_quiet(input int limit);
    int n;
    n = 0;
    while (idle_v != '0 && n < limit) begin
      tick(1);
      n++;
    end
    check_val("quiet", 32'(idle_v), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ef;
    int gap, f0, n;
    for (int i = 0; i < N; i++) begin
      d_prev[i] = 1'b0; frames[i] = 0; last_len[i] = 0; cap[i] = '1;
    end
    reset = 1'b1; wrsig = 1'b0; datain = 8'h00;
    tick(3);
    check_val("rst_tx", 32'(tx_v), 32'b111);
    check_val("rst_idle", 32'(idle_v), 32'd0);
    reset = 1'b0;
    tick(2);

    // single 0xA5 frame on every configuration
    pulse(8'hA5, 1);
    wait_quiet(400);
    check_val("a5_bits", 32'(cap[0][9:0]), 32'b1101001010);
    check_val("a5_len0", last_len[0], 160);
    check_val("a5_len1", last_len[1], 176);
    check_val("a5_len2", last_len[2], 44);

    // parity sense with 0x07 (three ones)
    tick(3);
    pulse(8'h07, 2);
    wait_quiet(400);
    check_val("par_even", 32'(cap[1][9]), 32'd1);
    check_val("par_odd", 32'(cap[2][8]), 32'd0);
    check_val("par_len", last_len[1], 176);

    // second edge mid-frame is dropped
    tick(2);
    f0 = frames[0];
    pulse(8'h3C, 1);
    tick(48);
    pulse(8'hFF, 1);
    wait_quiet(400);
    ef = f_frame(0, 8'h3C);
    check_val("drop_bits", 32'(cap[0][9:0]), 32'(ef[9:0]));
    check_val("drop_len", last_len[0], 160);
    check_val("drop_frames", frames[0] - f0, 1);

    // word sequencer: high byte then low byte back to back
    tick(2);
    pulse(8'h12, 1);
    n = 0;
    while (idle_v[0] && n < 400) begin tick(1); n++; end
    ef = f_frame(0, 8'h12);
    check_val("seq_hi", 32'(cap[0][9:0]), 32'(ef[9:0]));
    datain = 8'h34; wrsig = 1'b1;
    tick(1);
    wrsig = 1'b0;
    gap = 1;
    while (!idle_v[0] && gap < 10) begin tick(1); gap++; end
    check_val("seq_gap_le4", 32'(gap <= 4), 32'd1);
    wait_quiet(400);
    ef = f_frame(0, 8'h34);
    check_val("seq_lo", 32'(cap[0][9:0]), 32'(ef[9:0]));
    check_val("seq_lo_len", last_len[0], 160);

    // wrsig held high through reset release: no frame
    tick(2);
    reset = 1'b1; wrsig = 1'b1;
    tick(3);
    reset = 1'b0;
    f0 = frames[0] + frames[1] + frames[2];
    tick(500);
    check_val("hold_frames", frames[0] + frames[1] + frames[2] - f0, 0);
    check_val("hold_idle", 32'(idle_v), 32'd0);
    wrsig = 1'b0;
    tick(2);

    // reset at cycle 70 of a frame, then a clean frame
    pulse(8'hA5, 1);
    tick(69);
    reset = 1'b1;
    tick(1);
    check_val("abort_tx", 32'(tx_v), 32'b111);
    check_val("abort_idle", 32'(idle_v), 32'd0);
    reset = 1'b0;
    tick(2);
    pulse(8'h5A, 1);
    wait_quiet(400);
    ef = f_frame(0, 8'h5A);
    check_val("after_abort0", 32'(cap[0][9:0]), 32'(ef[9:0]));
    ef = f_frame(1, 8'h5A);
    check_val("after_abort1", 32'(cap[1][10:0]), 32'(ef[10:0]));
    check_val("after_abort_len", last_len[0], 160);

    // randomized traffic, checked cycle by cycle against the model
    repeat (25) begin
      pulse(8'($urandom_range(0, 255)), $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 60));
        pulse(8'($urandom_range(0, 255)), 1);
      end
      if ($urandom_range(0, 1) == 1) wait_quiet(400);
      tick($urandom_range(1, 20));
    end
    wait_quiet(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
